weight_ram_ctrl: RTL and testbench
==================================

# weight_ram_ctrl

Sequencer and arbiter for the single-port weight RAM (`ram_w`) in the IMG2COL GEMM datapath. It owns the RAM's one address/enable/write port and serves two clients: a weight loader that streams a block of weights in with valid/ready, and the GEMM engine that requests a contiguous burst read. It converts each accepted command into a cycle-exact sequence of RAM accesses and reports completion and errors.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): weight word width.
- `ADDR_SIZE`, default `` `ADDR_SIZE `` (10): RAM address width.
- `MEM_LENGTH`, default `` `MEM_LENGTH `` (1024): RAM depth in words.

- `clk` in 1: single clock, shared with the RAM's `clka`.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld_start` in 1: load command strobe; `ld_base` in ADDR_SIZE; `ld_len` in ADDR_SIZE+1.
- `ld_valid` in 1, `ld_data` in DATA_WIDTH, `ld_ready` out 1: weight stream.
- `rd_start` in 1: read command strobe; `rd_base` in ADDR_SIZE; `rd_len` in ADDR_SIZE+1.
- `rd_data` out DATA_WIDTH, `rd_valid` out 1, `rd_last` out 1: read stream, no backpressure.
- `busy` out 1, `done` out 1 (1-cycle pulse), `err` out 1 (1-cycle pulse).
- `ram_ena` out 1, `ram_wea` out 1, `ram_addra` out ADDR_SIZE, `ram_dina` out DATA_WIDTH: registered RAM controls.
- `ram_douta` in DATA_WIDTH: RAM read data, 1-cycle latency.

## Operation
- FSM states: IDLE, LOAD, LDRAIN, READ, RDRAIN.
- IDLE:
  - A valid `ld_start` goes to LOAD.
  - A valid `rd_start` goes to READ.
  - If both are strobed in the same cycle, the load wins. The read command is dropped and `err` pulses.
- Command check: a command is invalid when `len == 0` or `base + len > MEM_LENGTH`, computed at ADDR_SIZE+2 bits. An invalid command gives an `err` pulse on the next cycle and the FSM stays in IDLE.
- Strobes received outside IDLE are ignored, with no `err`.
- LOAD:
  - `ld_ready = 1`.
  - Each handshake (`ld_valid & ld_ready`) latches `ram_ena=1`, `ram_wea=1`, `ram_addra=ld_base+k`, `ram_dina=ld_data`, for k = 0..len-1.
  - The cycle the final beat is accepted, `ld_ready` drops (registered) and the FSM goes to LDRAIN.
- LDRAIN:
  - The final write is on the RAM port this cycle, and `done` pulses.
  - Next state is IDLE.
- READ: issues `ram_ena=1`, `ram_wea=0`, `ram_addra=rd_base+k` on consecutive cycles, one per cycle, with no gaps. After the final address it goes to RDRAIN.
- RDRAIN: last data returns; `done` and `rd_last` pulse together; next state is IDLE.
- `rd_data` = `ram_douta` passthrough. `rd_valid` is `ram_ena & ~ram_wea` delayed one cycle.
- `busy` = (state != IDLE).
- Address counter and beat counter are ADDR_SIZE+1 bits. The address never wraps, because the range check rejects any command that would.

## Timing
- Reset value 0 for all outputs, counters and `ram_*`; state resets to IDLE. RAM contents are not touched.
- Reset asserted mid-operation: abort immediately. A write already registered on the port is not guaranteed to land.
- Load, with `ld_start` sampled at edge 0:
  - `ld_ready` is high from cycle 1.
  - A beat accepted in cycle t writes in cycle t+1.
  - With `ld_valid` held high, a length-N load ends with `done` in cycle N+1. `busy` is low in cycle N+2, and a new start is accepted there.
- Read, with `rd_start` sampled at edge 0:
  - RAM reads are issued in cycles 1..N.
  - `rd_valid` is high in cycles 2..N+1.
  - `rd_last` and `done` fall in cycle N+1.
- Read throughput is 1 word/cycle. Load throughput is 1 word/cycle when `ld_valid` is continuous; gaps in `ld_valid` stall without penalty.
- `err` occurs 1 cycle after the offending strobe.

## Structure
- Shared package `weight_ram_pkg`:
  - state enum `wr_state_t`;
  - localparams `LEN_W = ADDR_SIZE+1` and `CHK_W = ADDR_SIZE+2`.
- Single module; no sub-module is needed.
- The bench instantiates `ram_w` as the RAM model.

## Test plan
- Load: `ld_start`, base 0, len 4, data 0x11..0x14 back-to-back.
  - Expect writes to addresses 0..3 in cycles 2..5, `done` in cycle 5, `busy` low in cycle 6.
- Read back: `rd_start`, base 0, len 4.
  - Expect `rd_valid` in cycles 2..5 with 0x11, 0x12, 0x13, 0x14; `rd_last` and `done` in cycle 5.
- Load, base 10, len 3, with `ld_valid` toggled 1-0-1-0-1.
  - Expect 3 writes only on accepted beats, to addresses 10..12, and `done` one cycle after the 3rd acceptance.
- Simultaneous `ld_start`/`rd_start` in IDLE.
  - Expect the load to proceed and `err` to pulse once.
- Bad commands:
  - len 0 gives an `err` pulse, no RAM access, and `busy` stays 0.
  - base 1020, len 5 (MEM_LENGTH 1024) gives an `err` pulse and no RAM access.
- Reset mid-read: `rst_n` low during the 3rd read cycle.
  - Expect all outputs 0 asynchronously.
  - After release, a read of base 0, len 1 returns 0x11.

Source files
------------

// File: rtl/weight_ram_pkg.sv
// weight_ram_pkg: shared types and widths for the weight RAM sequencer.
// Provides the FSM state enum and the counter / range-check widths.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 10
`endif
`ifndef MEM_LENGTH
`define MEM_LENGTH 1024
`endif

package weight_ram_pkg;

    localparam int LEN_W = `ADDR_SIZE + 1;
    localparam int CHK_W = `ADDR_SIZE + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LDRAIN,
        S_READ,
        S_RDRAIN
    } wr_state_t;

endpackage

// File: rtl/weight_ram_ctrl_if.sv
// weight_ram_ctrl_if: client-side bundle of the weight RAM sequencer.
// Carries load/read commands, the weight stream, the read stream and status.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 10
`endif

interface weight_ram_ctrl_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_SIZE  = `ADDR_SIZE
);
    logic                  ld_start;
    logic [ADDR_SIZE-1:0]  ld_base;
    logic [ADDR_SIZE:0]    ld_len;
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic                  rd_start;
    logic [ADDR_SIZE-1:0]  rd_base;
    logic [ADDR_SIZE:0]    rd_len;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output ld_start, ld_base, ld_len, ld_valid, ld_data,
        output rd_start, rd_base, rd_len,
        input  ld_ready, rd_data, rd_valid, rd_last,
        input  busy, done, err
    );

    modport slave (
        input  ld_start, ld_base, ld_len, ld_valid, ld_data,
        input  rd_start, rd_base, rd_len,
        output ld_ready, rd_data, rd_valid, rd_last,
        output busy, done, err
    );
endinterface

// File: rtl/ram_w.sv
// ram_w: single-port weight RAM, one registered read port (1-cycle latency).
// Ports: clka, ena, wea, addra, dina in; douta out.
module ram_w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int MEM_LENGTH = 1024
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_SIZE-1:0]  addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);
    logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            douta <= mem[addra];
        end
    end
endmodule

// File: rtl/weight_ram_ctrl.sv
// weight_ram_ctrl: owns the weight RAM port; turns load/read commands into
// RAM cycles. Ports: clk, rst_n, client bus (slave), registered ram_* out.
module weight_ram_ctrl
    import weight_ram_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int MEM_LENGTH = `MEM_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    weight_ram_ctrl_if.slave      bus,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta
);
    wr_state_t             state_q, state_d;
    logic [LEN_W-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  ld_ready_q, ld_ready_d;
    logic                  err_q, err_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ram_ena_q, ram_ena_d;
    logic                  ram_wea_q, ram_wea_d;
    logic [ADDR_SIZE-1:0]  ram_addra_q, ram_addra_d;
    logic [DATA_WIDTH-1:0] ram_dina_q, ram_dina_d;
    logic                  ld_bad, rd_bad;

    // Range check is one bit wider than the length so base+len cannot wrap.
    assign ld_bad = (bus.ld_len == '0) ||
        (CHK_W'(bus.ld_base) + CHK_W'(bus.ld_len) > CHK_W'(MEM_LENGTH));
    assign rd_bad = (bus.rd_len == '0) ||
        (CHK_W'(bus.rd_base) + CHK_W'(bus.rd_len) > CHK_W'(MEM_LENGTH));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        len_d       = len_q;
        err_d       = 1'b0;
        ram_ena_d   = 1'b0;
        ram_wea_d   = 1'b0;
        ram_addra_d = ram_addra_q;
        ram_dina_d  = ram_dina_q;
        rd_valid_d  = ram_ena_q & ~ram_wea_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ld_start) begin
                    // A read strobed alongside a load is dropped.
                    err_d = ld_bad | bus.rd_start;
                    if (!ld_bad) begin
                        state_d = S_LOAD;
                        addr_d  = LEN_W'(bus.ld_base);
                        beat_d  = '0;
                        len_d   = bus.ld_len;
                    end
                end else if (bus.rd_start) begin
                    err_d = rd_bad;
                    if (!rd_bad) begin
                        // First read address goes out on the accept edge.
                        state_d     = S_READ;
                        ram_ena_d   = 1'b1;
                        ram_addra_d = bus.rd_base;
                        addr_d      = LEN_W'(bus.rd_base) + LEN_W'(1);
                        beat_d      = LEN_W'(1);
                        len_d       = bus.rd_len;
                    end
                end
            end
            S_LOAD: begin
                if (bus.ld_valid && ld_ready_q) begin
                    ram_ena_d   = 1'b1;
                    ram_wea_d   = 1'b1;
                    ram_addra_d = addr_q[ADDR_SIZE-1:0];
                    ram_dina_d  = bus.ld_data;
                    addr_d      = addr_q + LEN_W'(1);
                    beat_d      = beat_q + LEN_W'(1);
                    if (beat_q + LEN_W'(1) == len_q) begin
                        state_d = S_LDRAIN;
                    end
                end
            end
            S_LDRAIN: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                // Top address bit set means the array end was passed.
                if (beat_q == len_q || addr_q[ADDR_SIZE]) begin
                    state_d = S_RDRAIN;
                end else begin
                    ram_ena_d   = 1'b1;
                    ram_addra_d = addr_q[ADDR_SIZE-1:0];
                    addr_d      = addr_q + LEN_W'(1);
                    beat_d      = beat_q + LEN_W'(1);
                end
            end
            S_RDRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Ready is registered: it drops the cycle after the last beat.
        ld_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            ld_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            ram_ena_q   <= 1'b0;
            ram_wea_q   <= 1'b0;
            ram_addra_q <= '0;
            ram_dina_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            ld_ready_q  <= ld_ready_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_valid_d;
            ram_ena_q   <= ram_ena_d;
            ram_wea_q   <= ram_wea_d;
            ram_addra_q <= ram_addra_d;
            ram_dina_q  <= ram_dina_d;
        end
    end

    assign bus.ld_ready = ld_ready_q;
    assign bus.rd_data  = ram_douta;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = (state_q == S_RDRAIN);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_LDRAIN) || (state_q == S_RDRAIN);
    assign bus.err      = err_q;
    assign ram_ena      = ram_ena_q;
    assign ram_wea      = ram_wea_q;
    assign ram_addra    = ram_addra_q;
    assign ram_dina     = ram_dina_q;
endmodule

// File: tb/tb_weight_ram_ctrl.sv
// tb_weight_ram_ctrl: directed stimulus with a queue scoreboard for the
// weight RAM sequencer; a negedge monitor checks RAM writes, reads, done, err.
module tb_weight_ram_ctrl;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int ML = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_ena, ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina, ram_douta;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct { int c; int a; int d; } wr_t;
    typedef struct { int c; int d; int l; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];
    int  done_q[$];
    int  err_q[$];

    weight_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();

    weight_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .MEM_LENGTH(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    ram_w #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .MEM_LENGTH(ML)) u_ram (
        .clka  (clk),
        .ena   (ram_ena),
        .wea   (ram_wea),
        .addra (ram_addra),
        .dina  (ram_dina),
        .douta (ram_douta)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        int  e;
        if (ram_ena && ram_wea) begin
            chk("wr_expected", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                chk("wr_cyc", cyc, w.c);
                chk("wr_addr", int'(ram_addra), w.a);
                chk("wr_data", int'(ram_dina), w.d);
            end
        end
        if (bus.rd_valid || bus.rd_last) begin
            chk("rd_expected", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
                r = rd_q.pop_front();
                chk("rd_cyc", cyc, r.c);
                chk("rd_valid", int'(bus.rd_valid), 1);
                chk("rd_data", int'(bus.rd_data), r.d);
                chk("rd_last", int'(bus.rd_last), r.l);
            end
        end
        if (bus.done) begin
            chk("done_expected", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                e = done_q.pop_front();
                chk("done_cyc", cyc, e);
            end
        end
        if (bus.err) begin
            chk("err_expected", int'(err_q.size() > 0), 1);
            if (err_q.size() > 0) begin
                e = err_q.pop_front();
                chk("err_cyc", cyc, e);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ld_ready"}, int'(bus.ld_ready), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
        chk({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
        chk({tag, "_rd_last"}, int'(bus.rd_last), 0);
        chk({tag, "_ram_ena"}, int'(ram_ena), 0);
        chk({tag, "_ram_wea"}, int'(ram_wea), 0);
        chk({tag, "_ram_addra"}, int'(ram_addra), 0);
        chk({tag, "_ram_dina"}, int'(ram_dina), 0);
    endtask

    // Continuous-valid load; optional simultaneous read strobe (dropped).
    task automatic load_cont(input int base, input int len, input int d0,
                             input bit with_rd);
        int s;
        @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_base  = AW'(base);
        bus.ld_len   = (AW+1)'(len);
        bus.rd_start = with_rd;
        bus.rd_base  = '0;
        bus.rd_len   = 11'd4;
        s = cyc + 1;
        if (with_rd) err_q.push_back(s);
        for (int k = 0; k < len; k++)
            wr_q.push_back('{c: s + 1 + k, a: base + k, d: (d0 + k) & 8'hff});
        done_q.push_back(s + len);
        @(negedge clk);
        bus.ld_start = 1'b0;
        bus.rd_start = 1'b0;
        for (int k = 0; k < len; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = DW'(d0 + k);
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'hEE;
        chk("ld_busy_drain", int'(bus.busy), 1);
        chk("ld_ready_drain", int'(bus.ld_ready), 0);
        @(negedge clk);
        chk("ld_busy_after", int'(bus.busy), 0);
    endtask

    task automatic read_cmd(input int base, input int len, input int d0);
        int s;
        @(negedge clk);
        bus.rd_start = 1'b1;
        bus.rd_base  = AW'(base);
        bus.rd_len   = (AW+1)'(len);
        s = cyc + 1;
        for (int k = 0; k < len; k++)
            rd_q.push_back('{c: s + 1 + k, d: (d0 + k) & 8'hff,
                             l: int'(k == len - 1)});
        done_q.push_back(s + len);
        @(negedge clk);
        bus.rd_start = 1'b0;
        repeat (len + 1) @(negedge clk);
        chk("rd_busy_after", int'(bus.busy), 0);
    endtask

    // Rejected command: err one cycle later, FSM stays idle.
    task automatic bad_cmd(input bit is_ld, input int base, input int len);
        int s;
        @(negedge clk);
        bus.ld_start = is_ld;
        bus.rd_start = !is_ld;
        bus.ld_base  = AW'(base);
        bus.rd_base  = AW'(base);
        bus.ld_len   = (AW+1)'(len);
        bus.rd_len   = (AW+1)'(len);
        s = cyc + 1;
        err_q.push_back(s);
        @(negedge clk);
        bus.ld_start = 1'b0;
        bus.rd_start = 1'b0;
        chk("bad_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        chk("bad_busy_later", int'(bus.busy), 0);
    endtask

    initial begin
        int s;
        bus.ld_start = 1'b0;
        bus.ld_base  = '0;
        bus.ld_len   = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.rd_start = 1'b0;
        bus.rd_base  = '0;
        bus.rd_len   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load_cont(0, 4, 8'h11, 1'b0);
        read_cmd(0, 4, 8'h11);

        // Gapped load at base 10; a read strobe mid-load must be ignored.
        @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_base  = 10'd10;
        bus.ld_len   = 11'd3;
        s = cyc + 1;
        wr_q.push_back('{c: s + 1, a: 10, d: 8'h31});
        wr_q.push_back('{c: s + 3, a: 11, d: 8'h32});
        wr_q.push_back('{c: s + 5, a: 12, d: 8'h33});
        done_q.push_back(s + 5);
        @(negedge clk);
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h31;
        @(negedge clk);
        chk("gap_ld_ready_c2", int'(bus.ld_ready), 1);
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'hEE;
        bus.rd_start = 1'b1;
        bus.rd_base  = '0;
        bus.rd_len   = 11'd1;
        @(negedge clk);
        bus.rd_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h32;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'hEE;
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h33;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'hEE;
        chk("gap_ld_ready_c6", int'(bus.ld_ready), 0);
        repeat (2) @(negedge clk);
        chk("gap_busy_after", int'(bus.busy), 0);
        read_cmd(10, 3, 8'h31);

        load_cont(20, 2, 8'hA0, 1'b1);
        read_cmd(20, 2, 8'hA0);

        bad_cmd(1'b1, 0, 0);
        bad_cmd(1'b0, 1020, 5);

        load_cont(1020, 4, 8'hC0, 1'b0);
        read_cmd(1020, 4, 8'hC0);

        // Reset during the third read cycle aborts the burst.
        @(negedge clk);
        bus.rd_start = 1'b1;
        bus.rd_base  = '0;
        bus.rd_len   = 11'd4;
        s = cyc + 1;
        rd_q.push_back('{c: s + 1, d: 8'h11, l: 0});
        rd_q.push_back('{c: s + 2, d: 8'h12, l: 0});
        @(negedge clk);
        bus.rd_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_cmd(0, 1, 8'h11);

        repeat (4) @(negedge clk);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        chk("err_q_empty", err_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
